adc_chan_arbiter: RTL and testbench
===================================

// Module: adc_chan_arbiter
// PURPOSE
//  Round-robin scheduler that merges N_CHAN independent ADC sample streams into the single
//  dv/chan/data stream consumed by the oversample filter and downstream PID stages.
//  - One-deep holding register per channel; at most one sample is issued per clock.
//  - Per-channel enable and sticky overrun flags are configured over the shared write bus.
// PARAMETERS
//  W_CHAN     5   channel index width
//  N_CHAN     8   number of requesting channels (N_CHAN <= 2**W_CHAN)
//  W_DATA     18  sample width (signed)
//  W_WR_ADDR  16  write-bus address width
//  W_WR_CHAN  16  write-bus channel width
//  W_WR_DATA  48  write-bus data width
//  W_OVR_CNT  16  overrun counter width (ARB_OVERRUN_CNT_EN only)
// PORTS
//  clk_in       in   1               system clock
//  rst_in       in   1               synchronous active-high reset
//  req_dv_in    in   N_CHAN          per-channel sample strobe
//  req_data_in  in   N_CHAN*W_DATA   packed samples; channel i = [i*W_DATA +: W_DATA]
//  wr_en        in   1               config write strobe
//  wr_addr      in   W_WR_ADDR       config address (ep_map.vh constants)
//  wr_chan      in   W_WR_CHAN       target channel
//  wr_data      in   W_WR_DATA       write payload
//  dv_out       out  1               output sample valid (single-cycle)
//  chan_out     out  W_CHAN          channel of issued sample
//  data_out     out  W_DATA          issued sample, signed
//  overrun_out  out  N_CHAN          sticky per-channel overrun flags
//  ovr_cnt_out  out  W_OVR_CNT       total overrun count (ARB_OVERRUN_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_in=1 at an edge): every hold valid=0; rr pointer=0; enable mask=all ones;
//    dv_out=0, chan_out=0, data_out=0, overrun_out=0, ovr_cnt_out=0. Mid-operation reset
//    discards all held samples; no dv_out is issued in the cycle after reset.
//  - Capture: if req_dv_in[i] is high and en[i]=1, hold[i] <= sample and hold_v[i] <= 1.
//    Samples on disabled channels are dropped silently; no overrun is flagged.
//  - Grant: each cycle, pick the first i with hold_v[i]=1, searching from rr pointer upward
//    and wrapping at N_CHAN-1 -> 0.
//    - Registered outputs: dv_out=1, chan_out=i, data_out=hold[i] on the next edge.
//    - hold_v[i] clears; rr <= i+1, with N_CHAN-1 wrapping to 0.
//    - If no hold is valid, dv_out=0, chan_out and data_out keep their last value, rr unchanged.
//  - Latency: req_dv_in -> dv_out is 2 cycles minimum; worst case is N_CHAN+1 cycles with all
//    channels busy.
//  - Capture and grant on the same channel in the same cycle: the old value is issued, the new
//    sample is held (hold_v stays 1), no overrun.
//  - Capture on a full, non-granted hold: the new sample overwrites the old one;
//    overrun_out[i] <= 1.
//  - Throughput: one sample/cycle aggregate. A channel strobing every cycle while all others
//    are idle never overruns.
//  - Disable write with en[i]=0: hold_v[i] clears on the same edge. A grant already computed
//    that cycle still issues.
// CONFIGURATION
//  - wr_addr==arb_chan_en_addr: en[wr_chan] <= wr_data[0].
//  - wr_addr==arb_ovr_clr_addr: overrun_out[wr_chan] <= 0. A new overrun on that channel in
//    the same cycle wins (flag reads 1).
//  - Writes with wr_chan >= N_CHAN are ignored. Writes to other addresses are ignored.
//  - Macro ARB_OVERRUN_CNT_EN:
//    - Defined: ovr_cnt_out exists. It increments by the number of overruns in each cycle,
//      saturating at all ones. A write to arb_ovr_clr_addr with wr_data[1]=1 zeroes it.
//    - Undefined: port, counter and wr_data[1] decode are absent; all other behaviour is
//      identical.
// TESTING
//  1. Reset, then req_dv_in[3]=1 with data -5 for 1 cycle -> 2 cycles later dv_out=1, chan_out=3,
//     data_out=-5 for exactly 1 cycle.
//  2. req_dv_in=8'hFF, data_i=i, for 1 cycle -> dv_out high 8 consecutive cycles, chan_out 0..7
//     in order, data_out=chan_out, no overrun.
//  3. Ch2 and ch5 strobe every cycle for 20 cycles -> output alternates 2,5,2,5...;
//     overrun_out[2] and overrun_out[5] are set (held data replaced before grant);
//     overrun_out of every other channel stays 0.
//  4. Ch1 strobes every cycle alone for 50 cycles -> dv_out high every cycle, data follows
//     input 2 cycles late, overrun_out=0.
//  5. Write en[4]=0, then strobe ch4 with 123 -> no dv_out. Re-enable, strobe 77 ->
//     chan_out=4, data_out=77.
//  6. Set overrun on ch0, assert rst_in mid-burst -> next cycle dv_out=0 and overrun_out=0.
//     With ARB_OVERRUN_CNT_EN, ovr_cnt_out=0; an arb_ovr_clr_addr write with wr_data=3 also
//     clears a nonzero count.

Source files
------------

// File: rtl/adc_chan_arbiter_if.sv
// adc_chan_arbiter_if
//   Bundles the per-channel sample request bus, the shared config write bus
//   and the merged output stream of adc_chan_arbiter.
//   master : sample sources / config writer (drives req_* and wr_*)
//   slave  : the arbiter (drives dv_out, chan_out, data_out, overrun_out)
//   ovr_cnt_out exists only when ARB_OVERRUN_CNT_EN is defined.
interface adc_chan_arbiter_if #(
    parameter int W_CHAN    = 5,
    parameter int N_CHAN    = 8,
    parameter int W_DATA    = 18,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48,
    parameter int W_OVR_CNT = 16
);
    logic [N_CHAN-1:0]        req_dv_in;
    logic [N_CHAN*W_DATA-1:0] req_data_in;
    logic                     wr_en;
    logic [W_WR_ADDR-1:0]     wr_addr;
    logic [W_WR_CHAN-1:0]     wr_chan;
    logic [W_WR_DATA-1:0]     wr_data;
    logic                     dv_out;
    logic [W_CHAN-1:0]        chan_out;
    logic signed [W_DATA-1:0] data_out;
    logic [N_CHAN-1:0]        overrun_out;
`ifdef ARB_OVERRUN_CNT_EN
    logic [W_OVR_CNT-1:0]     ovr_cnt_out;
`endif

    modport master (
        output req_dv_in, req_data_in, wr_en, wr_addr, wr_chan, wr_data,
        input  dv_out, chan_out, data_out, overrun_out
`ifdef ARB_OVERRUN_CNT_EN
        , ovr_cnt_out
`endif
    );

    modport slave (
        input  req_dv_in, req_data_in, wr_en, wr_addr, wr_chan, wr_data,
        output dv_out, chan_out, data_out, overrun_out
`ifdef ARB_OVERRUN_CNT_EN
        , ovr_cnt_out
`endif
    );
endinterface

// File: rtl/adc_chan_arbiter.sv
// adc_chan_arbiter
//   Round-robin scheduler merging N_CHAN ADC sample streams into one
//   dv/chan/data stream. One-deep hold register per channel, at most one
//   sample issued per clock, per-channel enable and sticky overrun flags
//   configured over the shared write bus.
// Ports
//   clk_in  : system clock
//   rst_in  : synchronous active-high reset
//   bus     : adc_chan_arbiter_if.slave (req_*, wr_*, dv/chan/data/overrun out)
// Optional feature
//   ARB_OVERRUN_CNT_EN : adds ovr_cnt_out, a saturating total overrun count,
//                        cleared by an ARB_OVR_CLR_ADDR write with wr_data[1]=1.
module adc_chan_arbiter #(
    parameter int W_CHAN    = 5,
    parameter int N_CHAN    = 8,
    parameter int W_DATA    = 18,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48,
    parameter int W_OVR_CNT = 16,
    parameter logic [W_WR_ADDR-1:0] ARB_CHAN_EN_ADDR = 16'h0040,
    parameter logic [W_WR_ADDR-1:0] ARB_OVR_CLR_ADDR = 16'h0041
) (
    input logic               clk_in,
    input logic               rst_in,
    adc_chan_arbiter_if.slave bus
);
    localparam int W_PTR = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [W_PTR:0] N_CHAN_P = (W_PTR + 1)'(N_CHAN);

    logic [N_CHAN-1:0][W_DATA-1:0] hold_q, hold_d;
    logic [N_CHAN-1:0]             hold_v_q, hold_v_d;
    logic [N_CHAN-1:0]             en_q, en_d;
    logic [N_CHAN-1:0]             ovr_q, ovr_d;
    logic [W_PTR-1:0]              rr_q, rr_d;
    logic                          dv_q, dv_d;
    logic [W_CHAN-1:0]             chan_q, chan_d;
    logic [W_DATA-1:0]             data_q, data_d;

    logic              found;
    logic [W_PTR-1:0]  gnt_idx;
    logic [W_PTR:0]    scan;
    logic [N_CHAN-1:0] gnt, cap, ovr_new;
    logic              wr_chan_ok, en_wr, clr_wr;
    logic [W_PTR-1:0]  wr_idx;

    assign wr_chan_ok = bus.wr_chan < W_WR_CHAN'(N_CHAN);
    assign wr_idx     = bus.wr_chan[W_PTR-1:0];
    assign en_wr      = bus.wr_en && wr_chan_ok && (bus.wr_addr == ARB_CHAN_EN_ADDR);
    assign clr_wr     = bus.wr_en && wr_chan_ok && (bus.wr_addr == ARB_OVR_CLR_ADDR);

    // Round-robin search starting at rr_q, wrapping at N_CHAN-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            scan = {1'b0, rr_q} + (W_PTR + 1)'(k);
            if (scan >= N_CHAN_P) scan = scan - N_CHAN_P;
            if (!found && hold_v_q[scan[W_PTR-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[W_PTR-1:0];
            end
        end
        gnt = '0;
        if (found) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        cap     = bus.req_dv_in & en_q;
        // A capture onto a hold being issued this cycle is not an overrun.
        ovr_new = cap & hold_v_q & ~gnt;

        hold_d   = hold_q;
        hold_v_d = cap | (hold_v_q & ~gnt);
        for (int i = 0; i < N_CHAN; i++)
            if (cap[i]) hold_d[i] = bus.req_data_in[i*W_DATA +: W_DATA];

        en_d = en_q;
        if (en_wr) begin
            en_d[wr_idx] = bus.wr_data[0];
            // Disabling drops whatever the channel holds, even a fresh capture.
            if (!bus.wr_data[0]) hold_v_d[wr_idx] = 1'b0;
        end

        // Clear first so a same-cycle overrun still sets the flag.
        ovr_d = ovr_q;
        if (clr_wr) ovr_d[wr_idx] = 1'b0;
        ovr_d = ovr_d | ovr_new;

        dv_d   = found;
        chan_d = found ? W_CHAN'(gnt_idx) : chan_q;
        data_d = found ? hold_q[gnt_idx] : data_q;
        rr_d   = rr_q;
        if (found) rr_d = (gnt_idx == W_PTR'(N_CHAN - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_q   <= '0;
            hold_v_q <= '0;
            en_q     <= '1;
            ovr_q    <= '0;
            rr_q     <= '0;
            dv_q     <= 1'b0;
            chan_q   <= '0;
            data_q   <= '0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            en_q     <= en_d;
            ovr_q    <= ovr_d;
            rr_q     <= rr_d;
            dv_q     <= dv_d;
            chan_q   <= chan_d;
            data_q   <= data_d;
        end
    end

    assign bus.dv_out      = dv_q;
    assign bus.chan_out    = chan_q;
    assign bus.data_out    = data_q;
    assign bus.overrun_out = ovr_q;

`ifdef ARB_OVERRUN_CNT_EN
    logic [W_OVR_CNT-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [W_OVR_CNT:0]   cnt_sum;
    logic                 unused_wr_data;

    // Clear zeroes the base; overruns of the same cycle are still counted.
    always_comb begin
        cnt_sum = (clr_wr && bus.wr_data[1]) ? '0 : {1'b0, ovr_cnt_q};
        for (int i = 0; i < N_CHAN; i++)
            cnt_sum = cnt_sum + (W_OVR_CNT + 1)'(ovr_new[i]);
        ovr_cnt_d = cnt_sum[W_OVR_CNT] ? '1 : cnt_sum[W_OVR_CNT-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) ovr_cnt_q <= '0;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign bus.ovr_cnt_out = ovr_cnt_q;
    assign unused_wr_data  = ^bus.wr_data[W_WR_DATA-1:2];
`else
    logic unused_wr_data;
    assign unused_wr_data = ^bus.wr_data[W_WR_DATA-1:1];
`endif
endmodule

// File: tb/tb_adc_chan_arbiter.sv
module tb_adc_chan_arbiter;
    localparam logic [15:0] EN_ADDR  = 16'h0040;
    localparam logic [15:0] CLR_ADDR = 16'h0041;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    adc_chan_arbiter_if bus ();

    adc_chan_arbiter #(
        .ARB_CHAN_EN_ADDR(EN_ADDR),
        .ARB_OVR_CLR_ADDR(CLR_ADDR)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_dv_in   = '0;
        bus.req_data_in = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_chan     = '0;
        bus.wr_data     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [15:0] addr, input logic [15:0] ch, input logic [47:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_chan = ch;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0 || bus.chan_out !== 5'd0 || bus.data_out !== 18'd0 ||
            bus.overrun_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got dv=%b chan=%0d data=%0d ovr=%h want all zero",
                     bus.dv_out, bus.chan_out, bus.data_out, bus.overrun_out);
        end
`ifdef ARB_OVERRUN_CNT_EN
        n_cmp++;
        if (bus.ovr_cnt_out !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d want 0", bus.ovr_cnt_out);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic signed [17:0] exp_d;
        exp_d = -18'sd5;
        do_reset();
        bus.req_dv_in[3] = 1'b1;
        bus.req_data_in[3*18 +: 18] = exp_d;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.dv_out !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: got dv=%b want 0", bus.dv_out);
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd3 || bus.data_out !== exp_d) begin
            n_bad++;
            $display("FAIL single_issue: got dv=%b chan=%0d data=%0d want 1/3/%0d",
                     bus.dv_out, bus.chan_out, bus.data_out, exp_d);
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0 || bus.chan_out !== 5'd3 || bus.data_out !== exp_d) begin
            n_bad++;
            $display("FAIL single_after: got dv=%b chan=%0d data=%0d want 0/3/%0d (held)",
                     bus.dv_out, bus.chan_out, bus.data_out, exp_d);
        end
    endtask

    task automatic test_all_channels();
        do_reset();
        bus.req_dv_in = 8'hFF;
        for (int i = 0; i < 8; i++) bus.req_data_in[i*18 +: 18] = 18'(i);
        tick();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'(k) || bus.data_out !== 18'(k)) begin
                n_bad++;
                $display("FAIL all_chan_%0d: got dv=%b chan=%0d data=%0d want 1/%0d/%0d",
                         k, bus.dv_out, bus.chan_out, bus.data_out, k, k);
            end
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0 || bus.overrun_out !== 8'h00) begin
            n_bad++;
            $display("FAIL all_chan_end: got dv=%b ovr=%h want 0/00", bus.dv_out, bus.overrun_out);
        end
    endtask

    task automatic test_two_streams();
        logic [4:0]         exp_c;
        logic signed [17:0] exp_d;
        do_reset();
        for (int j = 0; j < 20; j++) begin
            bus.req_dv_in = 8'b0010_0100;
            bus.req_data_in[2*18 +: 18] = 18'(j);
            bus.req_data_in[5*18 +: 18] = 18'(1000 + j);
            tick();
            // edge e = j+1 issues the sample driven at e-2
            if (j == 0) begin
                n_cmp++;
                if (bus.dv_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL two_first: got dv=%b want 0", bus.dv_out);
                end
            end else begin
                exp_c = ((j + 1) % 2 == 0) ? 5'd2 : 5'd5;
                exp_d = 18'((j - 1) + ((exp_c == 5'd5) ? 1000 : 0));
                n_cmp++;
                if (bus.dv_out !== 1'b1 || bus.chan_out !== exp_c || bus.data_out !== exp_d) begin
                    n_bad++;
                    $display("FAIL two_edge_%0d: got dv=%b chan=%0d data=%0d want 1/%0d/%0d",
                             j + 1, bus.dv_out, bus.chan_out, bus.data_out, exp_c, exp_d);
                end
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd5 || bus.data_out !== 18'sd1019) begin
            n_bad++;
            $display("FAIL two_drain5: got dv=%b chan=%0d data=%0d want 1/5/1019",
                     bus.dv_out, bus.chan_out, bus.data_out);
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd2 || bus.data_out !== 18'sd19) begin
            n_bad++;
            $display("FAIL two_drain2: got dv=%b chan=%0d data=%0d want 1/2/19",
                     bus.dv_out, bus.chan_out, bus.data_out);
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0 || bus.overrun_out !== 8'h24) begin
            n_bad++;
            $display("FAIL two_overrun: got dv=%b ovr=%h want 0/24", bus.dv_out, bus.overrun_out);
        end
        // clear ch2 only; out-of-range channel and foreign address are ignored
        cfg_write(CLR_ADDR, 16'd2, 48'd0);
        cfg_write(CLR_ADDR, 16'd8, 48'd0);
        cfg_write(CLR_ADDR + 16'd5, 16'd5, 48'd0);
        n_cmp++;
        if (bus.overrun_out !== 8'h20) begin
            n_bad++;
            $display("FAIL ovr_clear: got ovr=%h want 20", bus.overrun_out);
        end
    endtask

    task automatic test_single_stream();
        logic signed [17:0] exp_d;
        do_reset();
        for (int j = 0; j < 50; j++) begin
            bus.req_dv_in = 8'b0000_0010;
            bus.req_data_in[1*18 +: 18] = 18'(j * 3 - 70);
            tick();
            if (j > 0) begin
                exp_d = 18'((j - 1) * 3 - 70);
                n_cmp++;
                if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd1 || bus.data_out !== exp_d) begin
                    n_bad++;
                    $display("FAIL stream_edge_%0d: got dv=%b chan=%0d data=%0d want 1/1/%0d",
                             j + 1, bus.dv_out, bus.chan_out, bus.data_out, exp_d);
                end
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.data_out !== 18'sd77 || bus.overrun_out !== 8'h00) begin
            n_bad++;
            $display("FAIL stream_last: got dv=%b data=%0d ovr=%h want 1/77/00",
                     bus.dv_out, bus.data_out, bus.overrun_out);
        end
    endtask

    task automatic test_enable();
        do_reset();
        cfg_write(EN_ADDR, 16'd4, 48'd0);
        bus.req_dv_in[4] = 1'b1;
        bus.req_data_in[4*18 +: 18] = 18'd123;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bus.dv_out !== 1'b0) begin
                n_bad++;
                $display("FAIL disabled_ch4_%0d: got dv=%b want 0", k, bus.dv_out);
            end
        end
        cfg_write(EN_ADDR, 16'd4, 48'd1);
        bus.req_dv_in[4] = 1'b1;
        bus.req_data_in[4*18 +: 18] = 18'd77;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd4 || bus.data_out !== 18'sd77 ||
            bus.overrun_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reenabled_ch4: got dv=%b chan=%0d data=%0d ovr=%h want 1/4/77/00",
                     bus.dv_out, bus.chan_out, bus.data_out, bus.overrun_out);
        end
        // disable of a channel whose grant is already computed still issues;
        // a waiting hold on a disabled channel is dropped
        do_reset();
        bus.req_dv_in = 8'b0110_0000;
        bus.req_data_in[5*18 +: 18] = 18'd55;
        bus.req_data_in[6*18 +: 18] = 18'd66;
        tick();
        idle_inputs();
        cfg_write(EN_ADDR, 16'd6, 48'd0);
        n_cmp++;
        if (bus.dv_out !== 1'b1 || bus.chan_out !== 5'd5 || bus.data_out !== 18'sd55) begin
            n_bad++;
            $display("FAIL dis_grant5: got dv=%b chan=%0d data=%0d want 1/5/55",
                     bus.dv_out, bus.chan_out, bus.data_out);
        end
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0) begin
            n_bad++;
            $display("FAIL dis_drop6: got dv=%b chan=%0d want dv 0", bus.dv_out, bus.chan_out);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            bus.req_dv_in = 8'b0000_0011;
            bus.req_data_in[0 +: 18]  = 18'(j);
            bus.req_data_in[18 +: 18] = 18'(10 + j);
            tick();
        end
        n_cmp++;
        if (bus.overrun_out !== 8'h03) begin
            n_bad++;
            $display("FAIL burst_ovr: got ovr=%h want 03", bus.overrun_out);
        end
`ifdef ARB_OVERRUN_CNT_EN
        n_cmp++;
        if (bus.ovr_cnt_out !== 16'd2) begin
            n_bad++;
            $display("FAIL burst_cnt: got %0d want 2", bus.ovr_cnt_out);
        end
`endif
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0 || bus.overrun_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset: got dv=%b ovr=%h want 0/00", bus.dv_out, bus.overrun_out);
        end
`ifdef ARB_OVERRUN_CNT_EN
        n_cmp++;
        if (bus.ovr_cnt_out !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_cnt: got %0d want 0", bus.ovr_cnt_out);
        end
`endif
        rst = 1'b0;
        idle_inputs();
        tick();
        n_cmp++;
        if (bus.dv_out !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_dv: got dv=%b want 0", bus.dv_out);
        end
`ifdef ARB_OVERRUN_CNT_EN
        for (int j = 0; j < 3; j++) begin
            bus.req_dv_in = 8'b0000_0011;
            tick();
        end
        idle_inputs();
        cfg_write(CLR_ADDR, 16'd0, 48'd3);
        n_cmp++;
        if (bus.ovr_cnt_out !== 16'd0 || bus.overrun_out !== 8'h02) begin
            n_bad++;
            $display("FAIL cnt_clear: got cnt=%0d ovr=%h want 0/02", bus.ovr_cnt_out, bus.overrun_out);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_all_channels();
        test_two_streams();
        test_single_stream();
        test_enable();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
